// File: rtl/eth_fcs_tx_sequencer.sv
// Ethernet TX FCS sequencer: forwards the frame, drives a byte-serial CRC engine,
// zero-pads short frames, truncates long ones and appends the FCS LSB byte first.
module eth_fcs_tx_sequencer #(
  parameter int DATA_W  = 8,
  parameter int CRC_W   = 32,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int CNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              crc_init,
  output logic              crc_upd,
  output logic [DATA_W-1:0] crc_data,
  input  logic [CRC_W-1:0]  crc_result,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_len,
  output logic              err_oversize
);

  localparam int FCS_BYTES = CRC_W / DATA_W;
  localparam int IDX_W     = (FCS_BYTES > 1) ? $clog2(FCS_BYTES) : 1;
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FCS_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA     = 3'd1,
    PAD      = 3'd2,
    WAIT_CRC = 3'd3,
    FCS      = 3'd4,
    DISCARD  = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [CRC_W-1:0] fcs_r, fcs_nxt_s;
  logic [CNT_W-1:0] frame_len_r, frame_len_nxt_s;
  logic             discard_r, discard_nxt_s;
  logic             data_xfer_s;
  logic             at_max_s;

  assign cnt_inc_s   = cnt_r + CNT_ONE;
  assign at_max_s    = (cnt_inc_s == MAX_CNT);
  assign data_xfer_s = s_valid && m_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      fcs_r       <= {CRC_W{1'b0}};
      frame_len_r <= {CNT_W{1'b0}};
      discard_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      fcs_r       <= fcs_nxt_s;
      frame_len_r <= frame_len_nxt_s;
      discard_r   <= discard_nxt_s;
    end
  end

  // Next-state and handshake decode; rst forces the quiescent output values.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    idx_nxt_s       = idx_r;
    fcs_nxt_s       = fcs_r;
    frame_len_nxt_s = frame_len_r;
    discard_nxt_s   = discard_r;
    s_ready         = 1'b0;
    m_data          = {DATA_W{1'b0}};
    m_valid         = 1'b0;
    m_last          = 1'b0;
    crc_init        = 1'b0;
    crc_upd         = 1'b0;
    crc_data        = {DATA_W{1'b0}};
    busy            = 1'b0;
    err_oversize    = 1'b0;
    frame_len       = frame_len_r;
    case (state_r)
      IDLE: begin
        crc_init      = 1'b1;
        cnt_nxt_s     = {CNT_W{1'b0}};
        discard_nxt_s = 1'b0;
        if (s_valid) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        m_data   = s_data;
        crc_data = s_data;
        m_valid  = s_valid;
        s_ready  = m_ready;
        crc_upd  = data_xfer_s;
        if (data_xfer_s) begin
          cnt_nxt_s = cnt_inc_s;
          if (s_last || at_max_s) begin
            // Hitting MAX_LEN without s_last truncates; the rest is swallowed later.
            state_nxt_s   = (cnt_inc_s < MIN_CNT) ? PAD : WAIT_CRC;
            err_oversize  = at_max_s && !s_last;
            discard_nxt_s = at_max_s && !s_last;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      PAD: begin
        m_valid = 1'b1;
        crc_upd = m_ready;
        if (m_ready) begin
          cnt_nxt_s   = cnt_inc_s;
          state_nxt_s = (cnt_inc_s == MIN_CNT) ? WAIT_CRC : PAD;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      WAIT_CRC: begin
        // Engine output settles one cycle after the final update.
        fcs_nxt_s       = crc_result;
        frame_len_nxt_s = cnt_r;
        idx_nxt_s       = {IDX_W{1'b0}};
        state_nxt_s     = FCS;
      end
      FCS: begin
        m_valid = 1'b1;
        m_data  = fcs_r[DATA_W*int'(idx_r) +: DATA_W];
        m_last  = (idx_r == IDX_LAST);
        if (m_ready) begin
          idx_nxt_s = idx_r + IDX_ONE;
          if (idx_r == IDX_LAST) begin
            state_nxt_s = discard_r ? DISCARD : IDLE;
          end else begin
            state_nxt_s = FCS;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      DISCARD: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (rst) begin
      s_ready      = 1'b0;
      m_data       = {DATA_W{1'b0}};
      m_valid      = 1'b0;
      m_last       = 1'b0;
      crc_init     = 1'b1;
      crc_upd      = 1'b0;
      crc_data     = {DATA_W{1'b0}};
      err_oversize = 1'b0;
      busy         = 1'b0;
      frame_len    = {CNT_W{1'b0}};
    end else begin
      busy = (state_r != IDLE);
    end
  end

endmodule

// File: tb/tb_eth_fcs_tx_sequencer.sv
// Directed bench for eth_fcs_tx_sequencer with a constant-result CRC engine stub.
// A table of frame records drives the main cases; reset and back-to-back are hand sequences.
module tb_eth_fcs_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        crc_init;
  logic        crc_upd;
  logic [7:0]  crc_data;
  logic [31:0] crc_result;
  logic        busy;
  logic [11:0] frame_len;
  logic        err_oversize;

  localparam logic [31:0] FCS = 32'hDEADBEEF;
  assign crc_result = FCS;

  eth_fcs_tx_sequencer dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .crc_init(crc_init), .crc_upd(crc_upd), .crc_data(crc_data), .crc_result(crc_result),
    .busy(busy), .frame_len(frame_len), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int len;
    bit rnd;
    int exp_out;
    int exp_upd;
    int exp_flen;
    int exp_err;
    int exp_err_at;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame of bytes 0,1,2.. with s_last on the final byte; collects and checks the output.
  task automatic do_frame(input vec_t v, input string tag);
    logic [7:0] ob[$];
    int oc[$];
    int sent = 0, cyc = 0, upd = 0, errs = 0, err_at = -1;
    int rdy_bad = 0, upd_bad = 0, bad = 0, last_pos = -1, nlast = 0;
    int data_n = (v.len < 1514) ? v.len : 1514;
    bit done = 1'b0;
    logic [7:0] exp_b;
    while (!done && cyc < 5000) begin
      s_valid = (sent < v.len);
      s_data  = 8'(sent);
      s_last  = (sent == v.len - 1);
      m_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (crc_upd && !(m_valid && m_ready && crc_data == m_data)) upd_bad++;
      if (crc_upd) upd++;
      if (m_valid && s_valid && ob.size() < data_n && s_ready !== m_ready) rdy_bad++;
      if (m_valid && m_ready) begin
        ob.push_back(m_data);
        oc.push_back(cyc);
        if (m_last) begin
          nlast++;
          last_pos = ob.size() - 1;
        end
      end
      if (err_oversize) begin
        errs++;
        err_at = ob.size();
      end
      if (s_valid && s_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
      if (nlast > 0 && sent == v.len && !busy) done = 1'b1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int j = 0; j < ob.size(); j++) begin
      if (j < data_n) exp_b = 8'(j);
      else if (j < v.exp_flen) exp_b = 8'h00;
      else exp_b = 8'(FCS >> (8 * (j - v.exp_flen)));
      if (ob[j] !== exp_b) bad++;
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " out_count"}, ob.size(), v.exp_out);
    check({tag, " bad_bytes"}, bad, 0);
    check({tag, " m_last_count"}, nlast, 1);
    check({tag, " m_last_pos"}, last_pos, v.exp_out - 1);
    check({tag, " crc_upd_count"}, upd, v.exp_upd);
    check({tag, " crc_upd_qual"}, upd_bad, 0);
    check({tag, " frame_len"}, 32'(frame_len), v.exp_flen);
    check({tag, " err_count"}, errs, v.exp_err);
    check({tag, " err_pos"}, err_at, v.exp_err_at);
    check({tag, " s_ready_eq_m_ready"}, rdy_bad, 0);
    if (!v.rnd && ob.size() > v.exp_flen) begin
      check({tag, " first_byte_latency"}, oc[0], 1);
      check({tag, " fcs_gap"}, oc[v.exp_flen] - oc[v.exp_flen - 1], 2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " s_ready"}, 32'(s_ready), 0);
    check({tag, " m_valid"}, 32'(m_valid), 0);
    check({tag, " m_last"}, 32'(m_last), 0);
    check({tag, " crc_upd"}, 32'(crc_upd), 0);
    check({tag, " crc_init"}, 32'(crc_init), 1);
    check({tag, " err_oversize"}, 32'(err_oversize), 0);
    check({tag, " m_data"}, 32'(m_data), 0);
    check({tag, " crc_data"}, 32'(crc_data), 0);
    check({tag, " frame_len"}, 32'(frame_len), 0);
  endtask

  initial begin
    int sent, nl, upd, bubbles, init_bad, bad, cyc, nout;
    logic [7:0] exp_b;
    logic [7:0] ob[$];
    int k;

    vecs[0] = '{64,   1'b0, 68,   64,   64,   0, -1};
    vecs[1] = '{10,   1'b0, 64,   60,   60,   0, -1};
    vecs[2] = '{1600, 1'b0, 1518, 1514, 1514, 1, 1514};
    vecs[3] = '{100,  1'b1, 104,  100,  100,  0, -1};
    vecs[4] = '{60,   1'b0, 64,   60,   60,   0, -1};
    vecs[5] = '{1,    1'b0, 64,   60,   60,   0, -1};
    vecs[6] = '{1514, 1'b0, 1518, 1514, 1514, 0, -1};

    // Reset has priority even with input traffic present.
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 0);
    check("idle crc_init", 32'(crc_init), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      do_frame(vecs[i], $sformatf("frame%0d_len%0d", i, vecs[i].len));
    end

    // Reset while byte 30 of an 80-byte frame is in flight.
    sent = 0; nl = 0; cyc = 0;
    while (sent < 30 && cyc < 200) begin
      s_valid = 1'b1; s_data = 8'(sent); s_last = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      if (m_valid && m_ready && m_last) nl++;
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst bytes_before", sent, 30);
    rst = 1'b1; s_data = 8'(sent);
    @(negedge clk);
    check("midrst during busy", 32'(busy), 0);
    check("midrst during m_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("midrst after busy", 32'(busy), 0);
    check("midrst after m_valid", 32'(m_valid), 0);
    check("midrst after crc_init", 32'(crc_init), 1);
    check("midrst after frame_len", 32'(frame_len), 0);
    check("midrst no m_last", nl, 0);
    @(posedge clk); #1;
    do_frame(vecs[4], "post_reset_len60");

    // Two 60-byte frames with s_valid held high across the boundary.
    sent = 0; nl = 0; upd = 0; bubbles = 0; init_bad = 0; cyc = 0;
    ob.delete();
    while (!(nl == 2 && !busy) && cyc < 1000) begin
      s_valid = (sent < 120); s_data = 8'(sent);
      s_last = (sent == 59) || (sent == 119); m_ready = 1'b1;
      @(negedge clk);
      if (!busy && sent > 0 && sent < 120) bubbles++;
      if (!busy && !crc_init) init_bad++;
      if (crc_upd) upd++;
      if (m_valid && m_ready) begin
        ob.push_back(m_data);
        if (m_last) nl++;
      end
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    bad = 0;
    nout = ob.size();
    for (int j = 0; j < nout; j++) begin
      k = (j < 64) ? j : j - 64;
      if (k < 60) exp_b = 8'((j < 64) ? k : 60 + k);
      else exp_b = 8'(FCS >> (8 * (k - 60)));
      if (ob[j] !== exp_b) bad++;
    end
    check("b2b out_count", nout, 128);
    check("b2b bad_bytes", bad, 0);
    check("b2b m_last_count", nl, 2);
    check("b2b crc_upd_count", upd, 120);
    check("b2b bubbles", bubbles, 1);
    check("b2b idle_crc_init", init_bad, 0);
    check("b2b frame_len", 32'(frame_len), 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
